mod997_rr_scheduler: RTL and testbench
======================================

// Module: mod997_rr_scheduler
// PURPOSE
//  Shares one 200-bit mod-997 reduction core between NREQ requesters.
//  - Round-robin arbiter grants one request per cycle.
//  - Two-stage registered pipeline around the combinational core: operand register, then result register.
//  - Results return in grant order, tagged with the requester id.
//  - Sits between the accumulator/hash front-ends and the residue consumers.
// PARAMETERS
//  NREQ   4    number of requesters (2..8)
//  IDW    2    requester id width, = clog2(NREQ)
//  XW     200  operand width (fixed by the core)
//  RW     10   residue width (fixed by the core)
// PORTS
//  clk        in   1         single clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  req_valid  in   NREQ      per-requester operand valid
//  req_x      in   NREQ*XW   operands; requester i at [i*XW +: XW]
//  req_ready  out  NREQ      one-hot grant; transfer on valid&ready
//  out_valid  out  1         result valid
//  out_ready  in   1         consumer accepts result
//  out_r      out  RW        residue, X mod 997, range 0..996
//  out_id     out  IDW       requester that issued the operand
//  busy       out  1         any pipeline stage occupied
// BEHAVIOUR
//  Reset (clk edge with rst=1) clears these, with priority over all other activity:
//  - s1_v, s2_v, out_valid, busy = 0
//  - req_ready = 0; rr_ptr = 0; out_r = 0; out_id = 0
//  - In-flight operands are discarded. No output fires in the cycle after reset.
//  Pipeline (registered stages):
//  - s1 = {s1_v, s1_x, s1_id}: captures the granted operand.
//  - s2 = {s2_v, s2_r, s2_id}: captures core(s1_x); drives out_* directly.
//  - adv2 = !s2_v | out_ready; adv1 = !s1_v | adv2.
//  - On adv2: s2 <= s1, with s2_r = core(s1_x).
//  - On adv1: s1 <= granted request, or s1_v = 0 if no grant.
//  Latency and throughput:
//  - Grant in cycle t gives out_valid in cycle t+2 when out_ready stays high.
//  - Throughput is 1 result per cycle. Full-rate operation needs no bubbles.
//  Arbiter:
//  - req_ready is combinational: one-hot, gated by adv1.
//  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
//  - On a grant, rr_ptr <= (winner+1) mod NREQ. With no grant, rr_ptr holds.
//  - req_ready[i] never asserts while req_valid[i]=0.
//  - At most one ready bit is high per cycle.
//  - Starvation bound: a held request is granted within NREQ grants.
//  Handshake rules:
//  - Requesters hold req_valid and req_x stable until ready.
//  - out_valid, out_r and out_id hold stable while out_ready=0.
//  - Stall with both stages full: adv1 = 0, so all req_ready = 0 and nothing is lost.
//  - Simultaneous out accept and new grant in one cycle is legal: the pipeline shifts.
//  Arithmetic:
//  - The core returns a fully reduced residue in 0..996.
//  - out_r == req_x mod 997 exactly, for every 200-bit input including all-ones.
//  busy = s1_v | s2_v.
// STRUCTURE
//  Shared package mod997_pkg holds:
//  - MOD_P = 10'd997, XW = 200, RW = 10
//  - typedef req_tag_t: id, IDW bits
//  Sub-module mod997_core: combinational 200-bit -> 10-bit reduction, instantiated once.
//  The arbiter and the pipeline registers live in this module. No further hierarchy.
// TESTING
//  1. Single req0, X=1000, out_ready=1: grant cycle t -> out_valid at t+2, out_r=3, out_id=0.
//  2. X=997 -> 0; X=996 -> 996; X=1024 -> 27; X=2^20 -> 729;
//     X=2^200-1 -> reference-model value, checked against a bignum scoreboard.
//  3. All 4 req_valid held high, out_ready=1:
//     grants 0,1,2,3,0,...; out_id follows the same order, one result per cycle.
//  4. out_ready=0 for 5 cycles with all requesters valid:
//     - exactly 2 grants, then req_ready=0
//     - out_r/out_id frozen
//     - on release, results drain in order with no loss or duplication.
//  5. rst=1 while both stages are full:
//     next cycle out_valid=0, busy=0, rr_ptr=0; first post-reset grant goes to the lowest valid id.
//  6. 10k random cycles, random valid/ready:
//     scoreboard per id matches X mod 997; every request is granted within NREQ grants.

Source files
------------

// File: rtl/mod997_pkg.sv
// Shared constants and types for the mod-997 reduction scheduler.
package mod997_pkg;

  localparam logic [9:0] MOD_P    = 10'd997;
  localparam int         XW       = 200;
  localparam int         RW       = 10;
  localparam int         NREQ_DEF = 4;
  localparam int         IDW_DEF  = 2;
  // 2^10 mod 997: folding constant for each 10-bit chunk boundary.
  localparam logic [9:0] FOLD_K   = 10'd27;

  typedef logic [IDW_DEF-1:0] req_tag_t;

  function automatic int unsigned chunk_weight(input int unsigned k);
    int unsigned w;
    w = 32'd1;
    for (int unsigned i = 32'd0; i < k; i++) begin
      w = (w * 32'd1024) % 32'd997;
    end
    return w;
  endfunction

endpackage

// File: rtl/mod997_core.sv
// Combinational 200-bit -> 10-bit reduction modulo 997.
module mod997_core
  import mod997_pkg::*;
(
  input  logic [XW-1:0] x,
  output logic [RW-1:0] r
);

  localparam int NCH = XW / RW;

  logic [2*RW-1:0] prod_s [NCH];
  logic [24:0]     acc_s;
  logic [19:0]     f1_s;
  logic [14:0]     f2_s;
  logic [10:0]     f3_s;

  // Each 10-bit chunk k is weighted by 1024^k mod 997, so the sum stays congruent to x.
  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    localparam logic [RW-1:0] CW = RW'(chunk_weight(k));
    assign prod_s[k] = {10'd0, x[k*RW +: RW]} * {10'd0, CW};
  end

  always_comb begin
    acc_s = 25'd0;
    for (int k = 0; k < NCH; k++) begin
      acc_s = acc_s + 25'(prod_s[k]);
    end
  end

  // Repeated folding at bit 10 (1024 == 27 mod 997) shrinks the sum below 2*997.
  always_comb begin
    f1_s = 20'(acc_s[9:0]) + 20'(acc_s[24:10]) * 20'(FOLD_K);
    f2_s = 15'(f1_s[9:0]) + 15'(f1_s[19:10]) * 15'(FOLD_K);
    f3_s = 11'(f2_s[9:0]) + 11'(f2_s[14:10]) * 11'(FOLD_K);
    r    = (f3_s >= {1'b0, MOD_P}) ? RW'(f3_s - {1'b0, MOD_P}) : RW'(f3_s);
  end

endmodule

// File: rtl/mod997_rr_scheduler.sv
// Round-robin arbiter sharing one mod-997 core through a two-stage pipeline.
module mod997_rr_scheduler
  import mod997_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XW-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RW-1:0]        out_r,
  output logic [IDW-1:0]       out_id,
  output logic                 busy
);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           s1_v_q, s1_v_d;
  logic [XW-1:0]  s1_x_q, s1_x_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic           s2_v_q, s2_v_d;
  logic [RW-1:0]  s2_r_q, s2_r_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;

  logic           adv1_s, adv2_s;
  logic           found_s, hit_s, grant_en_s;
  logic [IDW-1:0] win_s;
  int             idx_s;
  logic [RW-1:0]  core_r_s;

  mod997_core u_core (
    .x (s1_x_q),
    .r (core_r_s)
  );

  assign adv2_s = !s2_v_q || out_ready;
  assign adv1_s = !s1_v_q || adv2_s;

  // Scan from rr_ptr upward (wrapping) and keep the first valid requester.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx_s   = int'(rr_ptr_q) + off;
      idx_s   = (idx_s >= NREQ) ? idx_s - NREQ : idx_s;
      hit_s   = !found_s && req_valid[idx_s];
      win_s   = hit_s ? IDW'(idx_s) : win_s;
      found_s = found_s || hit_s;
    end
    grant_en_s = found_s && adv1_s && !rst;
    req_ready  = grant_en_s ? (NREQ'(1) << win_s) : '0;
    rr_ptr_d   = grant_en_s ? ((int'(win_s) == NREQ - 1) ? '0 : win_s + IDW'(1)) : rr_ptr_q;
  end

  always_comb begin
    if (adv1_s) begin
      s1_v_d  = grant_en_s;
      s1_x_d  = grant_en_s ? req_x[int'(win_s)*XW +: XW] : s1_x_q;
      s1_id_d = grant_en_s ? win_s : s1_id_q;
    end else begin
      s1_v_d  = s1_v_q;
      s1_x_d  = s1_x_q;
      s1_id_d = s1_id_q;
    end
  end

  always_comb begin
    if (adv2_s) begin
      s2_v_d  = s1_v_q;
      s2_r_d  = core_r_s;
      s2_id_d = s1_id_q;
    end else begin
      s2_v_d  = s2_v_q;
      s2_r_d  = s2_r_q;
      s2_id_d = s2_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      s1_v_q   <= 1'b0;
      s1_x_q   <= '0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_r_q   <= '0;
      s2_id_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      s1_v_q   <= s1_v_d;
      s1_x_q   <= s1_x_d;
      s1_id_q  <= s1_id_d;
      s2_v_q   <= s2_v_d;
      s2_r_q   <= s2_r_d;
      s2_id_q  <= s2_id_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_r     = s2_r_q;
  assign out_id    = s2_id_q;
  assign busy      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_mod997_rr_scheduler.sv
// Directed and random self-checking bench for mod997_rr_scheduler.
module tb_mod997_rr_scheduler;

  localparam int NREQ = 4;
  localparam int XW   = 200;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [9:0]        out_r;
  logic [1:0]        out_id;
  logic              busy;

  int checks;
  int failures;

  typedef struct {
    logic [1:0] id;
    logic [9:0] r;
  } exp_t;

  exp_t          sbq[$];
  logic [XW-1:0] mx [NREQ];
  logic          pend [NREQ];
  int            waited [NREQ];
  logic [9:0]    res3 [NREQ];

  mod997_rr_scheduler #(.NREQ(NREQ), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: independent of any chunk folding.
  function automatic logic [9:0] ref_mod(input logic [XW-1:0] x);
    int unsigned r;
    r = 0;
    for (int i = XW - 1; i >= 0; i--) begin
      r = (r * 2 + 32'(x[i])) % 997;
    end
    return 10'(r);
  endfunction

  function automatic logic [XW-1:0] rand200();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[XW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int id, input logic [XW-1:0] x, input logic [9:0] expv, input string tag);
    cyc();
    req_valid = 4'b0001 << id;
    req_x[id*XW +: XW] = x;
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
    cyc();
    req_valid = 4'b0000;
    #1;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_lat1_busy"}, 32'(busy), 32'd1);
    cyc();
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_r"}, 32'(out_r), 32'(expv));
    chk({tag, "_id"}, 32'(out_id), 32'(id));
    cyc();
    #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [XW-1:0] big;
    logic          prev_stall;
    logic [9:0]    prev_r;
    logic [1:0]    prev_id;
    int            g;
    exp_t          e;

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_x     = '0;
    out_ready = 1'b1;

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Latency and arithmetic boundary values; last ids leave rr_ptr at 0
    single(0, 200'd1000, 10'd3, "x1000");
    single(1, 200'd997, 10'd0, "x997");
    single(2, 200'd996, 10'd996, "x996");
    single(3, 200'd1024, 10'd27, "x1024");
    big = '0;
    big[20] = 1'b1;
    single(2, big, 10'd729, "x2p20");
    big = '1;
    single(3, big, ref_mod(big), "xones");

    // Full-rate round robin
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*XW +: XW] = 200'(i * 1000 + 5);
    end
    res3[0] = 10'd5;
    res3[1] = 10'd8;
    res3[2] = 10'd11;
    res3[3] = 10'd14;
    for (int k = 0; k <= 12; k++) begin
      cyc();
      req_valid = (k < 10) ? 4'b1111 : 4'b0000;
      #1;
      chk("rr_ready", 32'(req_ready), (k < 10) ? 32'(4'b0001 << (k % 4)) : 32'd0);
      if (k >= 2 && k < 12) begin
        chk("rr_valid", 32'(out_valid), 32'd1);
        chk("rr_id", 32'(out_id), 32'((k - 2) % 4));
        chk("rr_r", 32'(out_r), 32'(res3[(k - 2) % 4]));
      end else begin
        chk("rr_novalid", 32'(out_valid), 32'd0);
      end
    end

    // Output stall for 5 cycles; rr_ptr starts at 2
    for (int k = 0; k < 8; k++) begin
      cyc();
      out_ready = (k >= 5) ? 1'b1 : 1'b0;
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      case (k)
        0: chk("st_ready0", 32'(req_ready), 32'(4'b0100));
        1: chk("st_ready1", 32'(req_ready), 32'(4'b1000));
        default: chk("st_ready_off", 32'(req_ready), 32'd0);
      endcase
      if (k >= 2 && k <= 5) begin
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_id", 32'(out_id), 32'd2);
        chk("st_r", 32'(out_r), 32'(res3[2]));
      end else if (k == 6) begin
        chk("st_valid6", 32'(out_valid), 32'd1);
        chk("st_id6", 32'(out_id), 32'd3);
        chk("st_r6", 32'(out_r), 32'(res3[3]));
      end else begin
        chk("st_novalid", 32'(out_valid), 32'd0);
      end
    end
    chk("st_idle", 32'(busy), 32'd0);

    // Reset with both stages full; rr_ptr is 2 before reset
    cyc();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rf_ready0", 32'(req_ready), 32'(4'b0001));
    cyc();
    #1;
    chk("rf_ready1", 32'(req_ready), 32'(4'b0010));
    cyc();
    #1;
    chk("rf_full_ready", 32'(req_ready), 32'd0);
    chk("rf_full_valid", 32'(out_valid), 32'd1);
    chk("rf_full_id", 32'(out_id), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("rf_rst_ready", 32'(req_ready), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rf_post_valid", 32'(out_valid), 32'd0);
    chk("rf_post_busy", 32'(busy), 32'd0);
    chk("rf_post_r", 32'(out_r), 32'd0);
    chk("rf_post_id", 32'(out_id), 32'd0);
    chk("rf_post_grant", 32'(req_ready), 32'(4'b0010));
    cyc();
    req_valid = 4'b0000;
    #1;
    chk("rf_lat1", 32'(out_valid), 32'd0);
    cyc();
    #1;
    chk("rf_out_valid", 32'(out_valid), 32'd1);
    chk("rf_out_id", 32'(out_id), 32'd1);
    chk("rf_out_r", 32'(out_r), 32'(res3[1]));
    cyc();
    #1;
    chk("rf_drained", 32'(busy), 32'd0);

    // Random traffic against a grant-order scoreboard; rr_ptr is 2 here
    for (int i = 0; i < NREQ; i++) begin
      pend[i]   = 1'b0;
      waited[i] = 0;
    end
    prev_stall = 1'b0;
    prev_r     = '0;
    prev_id    = '0;
    for (int c = 0; c < 10000; c++) begin
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i]   = 1'b1;
          waited[i] = 0;
          mx[i]     = ($urandom % 16 == 0) ? '1 : rand200();
          req_x[i*XW +: XW] = mx[i];
        end
        req_valid[i] = pend[i];
      end
      out_ready = ($urandom % 4 != 0);
      #1;
      chk("rnd_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      chk("rnd_ready_valid", 32'(req_ready & ~req_valid), 32'd0);
      if (prev_stall) begin
        chk("rnd_hold_valid", 32'(out_valid), 32'd1);
        chk("rnd_hold_r", 32'(out_r), 32'(prev_r));
        chk("rnd_hold_id", 32'(out_id), 32'(prev_id));
      end
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (req_ready[i]) g = i;
        end
        chk("rnd_starve", 32'(waited[g] < NREQ), 32'd1);
        e.id = 2'(g);
        e.r  = ref_mod(mx[g]);
        sbq.push_back(e);
        for (int i = 0; i < NREQ; i++) begin
          if (pend[i] && i != g) waited[i]++;
        end
        pend[g] = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk("rnd_sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("rnd_id", 32'(out_id), 32'(e.id));
          chk("rnd_r", 32'(out_r), 32'(e.r));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_r     = out_r;
      prev_id    = out_id;
    end

    // Drain whatever is still in flight
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_valid = '0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk("drain_sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("drain_id", 32'(out_id), 32'(e.id));
          chk("drain_r", 32'(out_r), 32'(e.r));
        end
      end
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
